// File: rtl/rp_8bit_trace_pkg.sv
// rp_8bit_trace_pkg: shared types and decode helpers for the rp_8bit instruction-trace collector.
//   cls_t        - 3-bit instruction class carried in every trace record.
//   RecFixedW    - record width excluding the PAW-wide pc field.
//   is_two_word  - detects the opcodes that are followed by a second word (lds/sts, jmp/call).
//   classify     - maps a first opcode word to its instruction class.
package rp_8bit_trace_pkg;

  // w0 + w1 + len2 + trunc + lost + cls
  localparam int unsigned RecFixedW = 38;

  localparam logic [15:0] LdsStsMask   = 16'hFC0F;
  localparam logic [15:0] LdsStsMatch  = 16'h9000;
  localparam logic [15:0] JmpCallMask  = 16'hFE0C;
  localparam logic [15:0] JmpCallMatch = 16'h940C;

  typedef enum logic [2:0] {
    ClsAlu    = 3'd0,
    ClsMul    = 3'd1,
    ClsMem    = 3'd2,
    ClsBranch = 3'd3,
    ClsCtrl   = 3'd4,
    ClsBit    = 3'd5,
    ClsUndef  = 3'd6
  } cls_t;

  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & LdsStsMask) == LdsStsMatch) || ((w & JmpCallMask) == JmpCallMatch);
  endfunction

  // Checks are ordered: earlier, narrower patterns take precedence over the broad ones below.
  function automatic cls_t classify(input logic [15:0] w);
    cls_t c;
    c = ClsUndef;
    if (w == 16'h0000)                          c = ClsCtrl;   // nop
    else if ((w & 16'hFF00) == 16'h0000)        c = ClsUndef;  // reserved 0x0001-0x00FF
    else if ((w & 16'hFF00) == 16'h0100)        c = ClsAlu;    // movw
    else if ((w & 16'hFE00) == 16'h0200)        c = ClsMul;    // muls/mulsu/fmul*
    else if ((w & 16'hFC00) == 16'h1000)        c = ClsBranch; // cpse (skip)
    else if ((w & 16'h8000) == 16'h0000)        c = ClsAlu;    // two-reg and immediate ALU
    else if ((w & 16'hD000) == 16'h8000)        c = ClsMem;    // ldd/std
    else if ((w & 16'hFC00) == 16'h9000)        c = ClsMem;    // lds/sts/ld/st/lpm/push/pop
    else if ((w & 16'hFE00) == 16'h9400) begin
      case (w[3:0])
        4'h4:                      c = ClsUndef;
        4'h8:                      c = w[8] ? ClsCtrl : ClsBit; // ret/sleep.. vs bset/bclr
        4'h9:                      c = ClsBranch;               // ijmp/icall
        4'hC, 4'hD, 4'hE, 4'hF:    c = ClsBranch;               // jmp/call
        default:                   c = ClsAlu;                  // one-operand ALU
      endcase
    end
    else if ((w & 16'hFE00) == 16'h9600)        c = ClsAlu;    // adiw/sbiw
    else if ((w & 16'hFC00) == 16'h9800)        c = ClsBit;    // cbi/sbic/sbi/sbis
    else if ((w & 16'hFC00) == 16'h9C00)        c = ClsMul;    // mul
    else if ((w & 16'hF000) == 16'hB000)        c = ClsMem;    // in/out
    else if ((w & 16'hE000) == 16'hC000)        c = ClsBranch; // rjmp/rcall
    else if ((w & 16'hF000) == 16'hE000)        c = ClsAlu;    // ldi
    else if ((w & 16'hF800) == 16'hF000)        c = ClsBranch; // brbs/brbc
    else if (w[3])                              c = ClsUndef;  // reserved bit-3 forms
    else                                        c = ClsBit;    // bld/bst/sbrc/sbrs
    return c;
  endfunction

endpackage

// File: rtl/rp_8bit_trace_fifo.sv
// rp_8bit_trace_fifo: generic synchronous FIFO for trace records.
//   push_i/data_i/full_o  - write side; a push while full is ignored unless a pop happens too.
//   pop_i/valid_o/data_o  - read side; data_o is zero whenever the FIFO is empty.
module rp_8bit_trace_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);
  localparam int unsigned Aw = $clog2(Depth);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [Aw:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;

  assign valid_o = (wr_ptr_q != rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign data_o  = valid_o ? mem_q[rd_ptr_q[Aw-1:0]] : '0;

  always_comb begin
    rd_en    = pop_i && valid_o;
    // A same-cycle pop frees the slot the push writes into.
    wr_en    = push_i && (!full_o || rd_en);
    wr_ptr_d = wr_ptr_q + {{Aw{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{Aw{1'b0}}, rd_en};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[Aw-1:0]] <= data_i;
  end

endmodule

// File: rtl/rp_8bit_trace.sv
// rp_8bit_trace: snoops the program-fetch stream, merges two-word opcodes into one record and
// buffers records for a valid/ready trace consumer.
//   if_vld/if_rdy/if_adr/if_dat - fetch word handshake; if_flush drops any pending first word.
//   trc_vld/trc_rdy/trc_rec      - record output {pc, w0, w1, len2, trunc, lost, cls}.
//   ovf/drop_cnt                 - sticky overflow flag and saturating count of dropped records.
module rp_8bit_trace
  import rp_8bit_trace_pkg::*;
#(
  parameter int unsigned PAW   = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_vld,
  output logic                     if_rdy,
  input  logic [PAW-1:0]           if_adr,
  input  logic [15:0]              if_dat,
  input  logic                     if_flush,
  output logic                     trc_vld,
  input  logic                     trc_rdy,
  output logic [PAW+RecFixedW-1:0] trc_rec,
  output logic                     ovf,
  output logic [CNTW-1:0]          drop_cnt
);
  typedef struct packed {
    logic [PAW-1:0] pc;
    logic [15:0]    w0;
    logic [15:0]    w1;
    logic           len2;
    logic           trunc;
    logic           lost;
    cls_t           cls;
  } rec_t;

  typedef enum logic [1:0] {StW1, StW2, StStash} state_e;

  state_e         state_q, state_d;
  logic [PAW-1:0] pc_q, pc_d, stash_adr_q, stash_adr_d, pc_inc;
  logic [15:0]    w0_q, w0_d, stash_dat_q, stash_dat_d;
  logic           lost_q, lost_d, ovf_q, ovf_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  logic           accept, push, drop, fifo_full, do_first;
  logic [PAW-1:0] first_adr;
  logic [15:0]    first_dat;
  rec_t           push_rec;

  assign if_rdy   = (state_q != StStash);
  assign accept   = if_vld && if_rdy;
  assign pc_inc   = pc_q + PAW'(1);
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    w0_d        = w0_q;
    stash_adr_d = stash_adr_q;
    stash_dat_d = stash_dat_q;
    push        = 1'b0;
    push_rec    = '0;
    do_first    = 1'b0;
    first_adr   = if_adr;
    first_dat   = if_dat;

    if (if_flush) begin
      // Pending w0/stash are abandoned; a word arriving now starts afresh.
      state_d  = StW1;
      do_first = accept;
    end else begin
      unique case (state_q)
        StW1: do_first = accept;
        StW2: begin
          if (accept) begin
            push          = 1'b1;
            push_rec.pc   = pc_q;
            push_rec.w0   = w0_q;
            push_rec.len2 = 1'b1;
            if (if_adr == pc_inc) begin
              push_rec.w1 = if_dat;
              state_d     = StW1;
            end else begin
              // Discontinuity: emit the orphan first word, replay the new word next cycle.
              push_rec.trunc = 1'b1;
              stash_adr_d    = if_adr;
              stash_dat_d    = if_dat;
              state_d        = StStash;
            end
          end
        end
        StStash: begin
          do_first  = 1'b1;
          first_adr = stash_adr_q;
          first_dat = stash_dat_q;
        end
        default: state_d = StW1;
      endcase
    end

    if (do_first) begin
      if (is_two_word(first_dat)) begin
        state_d = StW2;
        pc_d    = first_adr;
        w0_d    = first_dat;
      end else begin
        state_d     = StW1;
        push        = 1'b1;
        push_rec.pc = first_adr;
        push_rec.w0 = first_dat;
      end
    end

    push_rec.lost = lost_q;
    push_rec.cls  = classify(push_rec.w0);
  end

  always_comb begin
    // Full implies trc_vld, so only trc_rdy decides whether a slot frees up this cycle.
    drop       = push && fifo_full && !trc_rdy;
    lost_d     = lost_q;
    ovf_d      = ovf_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      lost_d = 1'b1;
      if (drop_cnt_q != {CNTW{1'b1}}) drop_cnt_d = drop_cnt_q + CNTW'(1);
    end else if (push) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StW1;
      pc_q        <= '0;
      w0_q        <= '0;
      stash_adr_q <= '0;
      stash_dat_q <= '0;
      lost_q      <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      w0_q        <= w0_d;
      stash_adr_q <= stash_adr_d;
      stash_dat_q <= stash_dat_d;
      lost_q      <= lost_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  rp_8bit_trace_fifo #(
    .Depth (DEPTH),
    .Width ($bits(rec_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_rec),
    .full_o  (fifo_full),
    .pop_i   (trc_rdy),
    .valid_o (trc_vld),
    .data_o  (trc_rec)
  );

endmodule

// File: tb/tb_rp_8bit_trace.sv
module tb_rp_8bit_trace;
  localparam int unsigned PAW = 16, DEPTH = 8, CNTW = 8, RW = PAW + 38;
  localparam logic [2:0] C_ALU = 3'd0, C_MUL = 3'd1, C_MEM = 3'd2, C_BRANCH = 3'd3,
                         C_CTRL = 3'd4, C_BIT = 3'd5, C_UNDEF = 3'd6;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           if_vld = 1'b0, if_flush = 1'b0, trc_rdy = 1'b0;
  logic [PAW-1:0] if_adr = '0;
  logic [15:0]    if_dat = '0;
  logic           if_rdy, trc_vld, ovf;
  logic [RW-1:0]  trc_rec;
  logic [CNTW-1:0] drop_cnt;

  always #5 clk = ~clk;

  rp_8bit_trace #(.PAW(PAW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_vld   (if_vld),
    .if_rdy   (if_rdy),
    .if_adr   (if_adr),
    .if_dat   (if_dat),
    .if_flush (if_flush),
    .trc_vld  (trc_vld),
    .trc_rdy  (trc_rdy),
    .trc_rec  (trc_rec),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  int n_checks = 0, n_errors = 0;

  // Reference model: pending first word, stashed replay word, record queue, drop bookkeeping.
  logic [RW-1:0] m_q[$];
  bit            m_pend, m_stash, m_lost, m_ovf, last_acc;
  logic [15:0]   m_pc, m_w0, m_sadr, m_sdat;
  int            m_drop;

  typedef struct packed {
    logic [15:0] w0;
    logic [2:0]  cls;
    logic        len2;
  } cls_vec_t;
  cls_vec_t tbl [0:26];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_two_word(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  // Class by opcode nibble, following the AVR opcode map.
  function automatic logic [2:0] ref_cls(input logic [15:0] w);
    case (w[15:12])
      4'h0: begin
        if (w == 16'h0000) return C_CTRL;
        if (w[11:8] == 4'h0) return C_UNDEF;
        if (w[11:8] == 4'h1) return C_ALU;
        if (w[11:9] == 3'b001) return C_MUL;
        return C_ALU;
      end
      4'h1: return (w[11:10] == 2'b00) ? C_BRANCH : C_ALU;
      4'h8, 4'hA, 4'hB: return C_MEM;
      4'hC, 4'hD: return C_BRANCH;
      4'h9: begin
        case (w[11:9])
          3'b000, 3'b001: return C_MEM;
          3'b010: begin
            if (w[3:0] == 4'h4) return C_UNDEF;
            if (w[3:0] == 4'h8) return w[8] ? C_CTRL : C_BIT;
            if (w[3:0] == 4'h9 || w[3:2] == 2'b11) return C_BRANCH;
            return C_ALU;
          end
          3'b011: return C_ALU;
          3'b100, 3'b101: return C_BIT;
          default: return C_MUL;
        endcase
      end
      4'hF: begin
        if (!w[11]) return C_BRANCH;
        return w[3] ? C_UNDEF : C_BIT;
      end
      default: return C_ALU;
    endcase
  endfunction

  function automatic logic [RW-1:0] mk_rec(input logic [15:0] pc, w0, w1, input bit len2, trunc,
                                           lost, input logic [2:0] cls);
    return {pc, w0, w1, len2, trunc, lost, cls};
  endfunction

  task automatic m_push(input logic [15:0] pc, w0, w1, input bit len2, trunc);
    if (m_q.size() < DEPTH) begin
      m_q.push_back(mk_rec(pc, w0, w1, len2, trunc, m_lost, ref_cls(w0)));
      m_lost = 0;
    end else begin
      if (m_drop < 255) m_drop++;
      m_ovf  = 1;
      m_lost = 1;
    end
  endtask

  task automatic m_first(input logic [15:0] adr, dat);
    if (ref_two_word(dat)) begin
      m_pend = 1;
      m_pc   = adr;
      m_w0   = dat;
    end else begin
      m_push(adr, dat, 16'h0, 0, 0);
    end
  endtask

  // One clock: drive at the falling edge, advance the model, compare after the rising edge.
  task automatic step(input bit vld, input logic [15:0] adr, dat, input bit flush, rdy);
    bit acc;
    logic [15:0] nxt;
    if_vld = vld; if_adr = adr; if_dat = dat; if_flush = flush; trc_rdy = rdy;
    chk("if_rdy", if_rdy, !m_stash);
    acc = vld && !m_stash;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    nxt = m_pc + 16'd1;
    if (flush) begin
      m_pend = 0; m_stash = 0;
      if (acc) m_first(adr, dat);
    end else if (m_stash) begin
      m_stash = 0;
      m_first(m_sadr, m_sdat);
    end else if (acc) begin
      if (!m_pend) m_first(adr, dat);
      else begin
        m_pend = 0;
        if (adr == nxt) m_push(m_pc, m_w0, dat, 1, 0);
        else begin
          m_push(m_pc, m_w0, 16'h0, 1, 1);
          m_stash = 1; m_sadr = adr; m_sdat = dat;
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    chk("trc_vld", trc_vld, m_q.size() > 0);
    chk("trc_rec", trc_rec, (m_q.size() > 0) ? m_q[0] : '0);
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic send(input logic [15:0] adr, dat, input bit rdy);
    step(1, adr, dat, 0, rdy);
    if (!last_acc) step(1, adr, dat, 0, rdy);
  endtask

  task automatic drain();
    while (m_q.size() > 0) step(0, 16'h0, 16'h0, 0, 1);
  endtask

  task automatic do_reset();
    if_vld = 0; if_flush = 0; trc_rdy = 0;
    rst_n = 0;
    #2;
    chk("rst_trc_vld", trc_vld, 0);
    chk("rst_trc_rec", trc_rec, 0);
    chk("rst_if_rdy", if_rdy, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    m_q.delete();
    m_pend = 0; m_stash = 0; m_lost = 0; m_ovf = 0; m_drop = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: return 16'h9000 | (r & 16'h03F0);
      1: return 16'h940C | (r & 16'h01F3);
      default: return r;
    endcase
  endfunction

  initial begin
    logic [15:0] r_adr, r_dat;
    bit have, v, fl, rd;

    tbl = '{
      '{16'h0000, C_CTRL,   1'b0}, '{16'h0055, C_UNDEF,  1'b0}, '{16'h0123, C_ALU,    1'b0},
      '{16'h0234, C_MUL,    1'b0}, '{16'h1234, C_BRANCH, 1'b0}, '{16'h1C00, C_ALU,    1'b0},
      '{16'h2C01, C_ALU,    1'b0}, '{16'h8108, C_MEM,    1'b0}, '{16'hA208, C_MEM,    1'b0},
      '{16'h900F, C_MEM,    1'b0}, '{16'h9100, C_MEM,    1'b1}, '{16'h9403, C_ALU,    1'b0},
      '{16'h9404, C_UNDEF,  1'b0}, '{16'h9408, C_BIT,    1'b0}, '{16'h9508, C_CTRL,   1'b0},
      '{16'h9409, C_BRANCH, 1'b0}, '{16'h940C, C_BRANCH, 1'b1}, '{16'h9602, C_ALU,    1'b0},
      '{16'h9A01, C_BIT,    1'b0}, '{16'h9C01, C_MUL,    1'b0}, '{16'hB001, C_MEM,    1'b0},
      '{16'hC005, C_BRANCH, 1'b0}, '{16'hD005, C_BRANCH, 1'b0}, '{16'hE0F5, C_ALU,    1'b0},
      '{16'hF001, C_BRANCH, 1'b0}, '{16'hF801, C_BIT,    1'b0}, '{16'hF808, C_UNDEF,  1'b0}
    };

    @(negedge clk);
    do_reset();

    // nop then jmp, sequential
    send(16'h0000, 16'h0000, 0);
    send(16'h0001, 16'h940C, 0);
    send(16'h0002, 16'h1234, 0);
    chk("seq_nop", trc_rec, mk_rec(16'h0000, 16'h0000, 16'h0, 0, 0, 0, C_CTRL));
    step(0, 16'h0, 16'h0, 0, 1);
    chk("seq_jmp", trc_rec, mk_rec(16'h0001, 16'h940C, 16'h1234, 1, 0, 0, C_BRANCH));
    drain();

    // class table
    for (int i = 0; i < 27; i++) begin
      logic [15:0] pc;
      pc = 16'h0100 + 16'(i * 4);
      send(pc, tbl[i].w0, 0);
      if (tbl[i].len2) send(pc + 16'd1, 16'hABCD, 0);
      chk($sformatf("tbl%0d", i), trc_rec,
          mk_rec(pc, tbl[i].w0, tbl[i].len2 ? 16'hABCD : 16'h0, tbl[i].len2, 0, 0, tbl[i].cls));
      drain();
    end

    // lds followed by a discontinuous fetch
    send(16'h0010, 16'h9100, 0);
    send(16'h0020, 16'hE0F5, 0);
    chk("lds_stall", if_rdy, 0);
    chk("lds_trunc", trc_rec, mk_rec(16'h0010, 16'h9100, 16'h0, 1, 1, 0, C_MEM));
    step(0, 16'h0, 16'h0, 0, 0);
    chk("lds_resume", if_rdy, 1);
    step(0, 16'h0, 16'h0, 0, 1);
    chk("lds_ldi", trc_rec, mk_rec(16'h0020, 16'hE0F5, 16'h0, 0, 0, 0, C_ALU));
    drain();

    // sts then flush
    send(16'h0005, 16'h9200, 1);
    step(0, 16'h0, 16'h0, 1, 1);
    chk("flush_norec", trc_vld, 0);
    send(16'h0030, 16'hE123, 0);
    chk("flush_next", trc_rec, mk_rec(16'h0030, 16'hE123, 16'h0, 0, 0, 0, C_ALU));
    drain();

    // address wrap on a call
    send(16'hFFFF, 16'h940E, 0);
    send(16'h0000, 16'h0100, 0);
    chk("wrap_call", trc_rec, mk_rec(16'hFFFF, 16'h940E, 16'h0100, 1, 0, 0, C_BRANCH));
    drain();

    // overflow and lost flag
    for (int i = 0; i < DEPTH + 3; i++) send(16'h0040 + 16'(i), 16'hE000 | 16'(i), 0);
    chk("ovf_cnt", drop_cnt, 3);
    chk("ovf_flag", ovf, 1);
    drain();
    send(16'h0060, 16'hE0AA, 0);
    chk("lost_set", trc_rec, mk_rec(16'h0060, 16'hE0AA, 16'h0, 0, 0, 1, C_ALU));
    step(0, 16'h0, 16'h0, 0, 1);
    send(16'h0061, 16'hE0BB, 0);
    chk("lost_clr", trc_rec, mk_rec(16'h0061, 16'hE0BB, 16'h0, 0, 0, 0, C_ALU));
    drain();

    // reset while in W2 with two records held
    send(16'h0070, 16'hE001, 0);
    send(16'h0071, 16'hE002, 0);
    send(16'h0072, 16'h9000, 0);
    do_reset();
    send(16'h0080, 16'hE003, 0);
    chk("post_rst", trc_rec, mk_rec(16'h0080, 16'hE003, 16'h0, 0, 0, 0, C_ALU));
    drain();

    // randomized stream
    r_adr = 16'h0200;
    r_dat = 16'h0;
    have  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!have) begin
        r_dat = pick_word();
        have  = 1;
      end
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 31) == 0);
      rd = ((c % 400) < 100) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(v, r_adr, r_dat, fl, rd);
      if (last_acc) begin
        have  = 0;
        r_adr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : r_adr + 16'd1;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
